// File: rtl/mem_stage.sv
// Memory-access stage of the RV64 pipeline: issues loads and stores over a
// valid/ready data-memory port, stalls upstream while busy, formats load data.
module mem_stage #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic [XLEN-1:0]     alures_i,
    input  logic [XLEN-1:0]     stdata_i,
    input  logic [2:0]          funct3_i,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic                wben_i,
    input  logic [XLEN-1:0]     csrdata_i,
    output logic                stall_o,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [XLEN-1:0]     dmem_addr,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [7:0]          dmem_wmask,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                out_valid,
    output logic [XLEN-1:0]     pc_o,
    output logic [INST_LEN-1:0] instr_o,
    output logic [XLEN-1:0]     alures_o,
    output logic                wben_o,
    output logic [XLEN-1:0]     csrdata_o,
    output logic [XLEN-1:0]     lsres_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] lsres_q, lsres_d;

    logic [2:0]      off_s;
    logic [3:0]      size_s;
    logic [7:0]      lane_mask_s;
    logic            mem_op_s;
    logic            misalign_s;
    logic            go_s;
    logic [XLEN-1:0] load_fmt_s;

    // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] rdata,
        input logic [2:0]      off,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  format_load = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  format_load = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  format_load = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  format_load = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b110:  format_load = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: format_load = sh;
        endcase
    endfunction

    // Access decode: offset, size, lane mask and misalignment.
    always_comb begin
        off_s    = alures_i[2:0];
        size_s   = 4'd1 << funct3_i[1:0];
        mem_op_s = (is_load_i | is_store_i) & in_valid;
        case (funct3_i[1:0])
            2'b00:   lane_mask_s = 8'h01 << off_s;
            2'b01:   lane_mask_s = 8'h03 << off_s;
            2'b10:   lane_mask_s = 8'h0F << off_s;
            default: lane_mask_s = 8'hFF << off_s;
        endcase
        misalign_s = mem_op_s & (({1'b0, off_s} + size_s) > 4'd8);
        go_s       = mem_op_s & ~misalign_s;
        load_fmt_s = format_load(dmem_rdata, off_s, funct3_i);
    end

    // Next-state logic for the access sequencer and the load-result register.
    always_comb begin
        state_d = state_q;
        lsres_d = lsres_q;
        case (state_q)
            S_IDLE: begin
                if (go_s) begin
                    state_d = dmem_req_ready ? S_RESP : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                if (dmem_resp_valid) begin
                    state_d = S_DONE;
                    lsres_d = is_load_i ? load_fmt_s : {XLEN{1'b0}};
                end else begin
                    state_d = S_RESP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and load-result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lsres_q <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            lsres_q <= lsres_d;
        end
    end

    // Output decode; every output is forced low while reset is asserted.
    always_comb begin
        stall_o        = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_addr      = {XLEN{1'b0}};
        dmem_we        = 1'b0;
        dmem_wdata     = {XLEN{1'b0}};
        dmem_wmask     = 8'h00;
        out_valid      = 1'b0;
        pc_o           = {XLEN{1'b0}};
        instr_o        = {INST_LEN{1'b0}};
        alures_o       = {XLEN{1'b0}};
        wben_o         = 1'b0;
        csrdata_o      = {XLEN{1'b0}};
        lsres_o        = {XLEN{1'b0}};
        misalign_o     = 1'b0;
        if (rst) begin
            stall_o = 1'b0;
        end else begin
            pc_o      = pc_i;
            instr_o   = instr_i;
            alures_o  = alures_i;
            csrdata_o = csrdata_i;
            dmem_req_valid = ((state_q == S_IDLE) & go_s) | (state_q == S_REQ);
            stall_o        = dmem_req_valid | (state_q == S_RESP);
            out_valid      = ((state_q == S_IDLE) & in_valid & ~go_s) | (state_q == S_DONE);
            misalign_o     = (state_q == S_IDLE) & misalign_s;
            wben_o         = wben_i & out_valid & ~misalign_o;
            if (dmem_req_valid) begin
                dmem_addr  = {alures_i[XLEN-1:3], 3'b000};
                dmem_we    = is_store_i;
                dmem_wdata = stdata_i << {off_s, 3'b000};
                dmem_wmask = lane_mask_s;
            end else begin
                dmem_addr  = {XLEN{1'b0}};
            end
            if (state_q == S_DONE) begin
                lsres_o = lsres_q;
            end else begin
                lsres_o = {XLEN{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written reset/misalign
// sequences and randomized accesses checked against a byte-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] pc_i;
    logic [31:0] instr_i;
    logic [63:0] alures_i, stdata_i, csrdata_i;
    logic [2:0]  funct3_i;
    logic        is_load_i, is_store_i, wben_i;
    logic        stall_o, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_resp_valid, out_valid, wben_o, misalign_o;
    logic [63:0] pc_o, alures_o, csrdata_o, lsres_o;
    logic [31:0] instr_o;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_i(pc_i), .instr_i(instr_i),
        .alures_i(alures_i), .stdata_i(stdata_i), .funct3_i(funct3_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .wben_i(wben_i),
        .csrdata_i(csrdata_i), .stall_o(stall_o), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .pc_o(pc_o), .instr_o(instr_o), .alures_o(alures_o),
        .wben_o(wben_o), .csrdata_o(csrdata_o), .lsres_o(lsres_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Byte-level reference: lane i is written iff off <= i < off+size.
    function automatic logic [7:0] m_mask(input int off, input int sz);
        logic [7:0] m;
        for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + sz);
        return m;
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Load result: take sz bytes starting at byte off, extend per funct3[2].
    function automatic logic [63:0] m_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
        logic [63:0] v;
        int          sz;
        logic        sgn;
        sz  = m_size(f3);
        v   = rd >> (8 * off);
        sgn = (f3[2] == 1'b0) && (sz < 8) && v[8*sz-1];
        for (int b = 0; b < 64; b++) if (b >= 8 * sz) v[b] = sgn;
        return v;
    endfunction

    task automatic clear_inputs();
        in_valid = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; wben_i = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    endtask

    // One aligned memory access: ready after rdy cycles, response rspd cycles
    // after acceptance, DONE one cycle later. Checks every cycle.
    task automatic run_mem(input logic [63:0] addr, input logic [2:0] f3, input logic ld,
                           input logic [63:0] sd, input logic [63:0] rd, input int rdy,
                           input int rspd, input logic junk, input logic wb,
                           input logic [63:0] e_ls, input logic [7:0] e_mask,
                           input logic [63:0] e_wdata);
        int          d;
        logic [63:0] pc;
        d  = rdy + rspd + 1;
        pc = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b1; alures_i = addr; funct3_i = f3; is_load_i = ld; is_store_i = ~ld;
        stdata_i = sd; wben_i = wb; pc_i = pc; csrdata_i = {$urandom, $urandom};
        for (int c = 0; c <= d; c++) begin
            dmem_req_ready  = (c == rdy);
            dmem_resp_valid = (c == rdy + rspd) || (junk && c == rdy);
            dmem_rdata      = (c == rdy + rspd) ? rd : ~rd;
            #4;
            check("req_valid", {63'd0, dmem_req_valid}, {63'd0, c <= rdy});
            check("stall", {63'd0, stall_o}, {63'd0, c < d});
            check("out_valid", {63'd0, out_valid}, {63'd0, c == d});
            if (c <= rdy) begin
                check("addr", dmem_addr, {addr[63:3], 3'b000});
                check("we", {63'd0, dmem_we}, {63'd0, ~ld});
                if (!ld) begin
                    check("wmask", {56'd0, dmem_wmask}, {56'd0, e_mask});
                    check("wdata", dmem_wdata, e_wdata);
                end
            end
            if (c == d) begin
                check("lsres", lsres_o, e_ls);
                check("wben", {63'd0, wben_o}, {63'd0, wb});
                check("misalign", {63'd0, misalign_o}, 64'd0);
                check("alures_o", alures_o, addr);
                check("pc_o", pc_o, pc);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic run_misaligned(input logic [63:0] addr, input logic [2:0] f3, input logic ld);
        @(posedge clk); #1;
        in_valid = 1'b1; alures_i = addr; funct3_i = f3; is_load_i = ld; is_store_i = ~ld;
        wben_i = 1'b1; dmem_req_ready = 1'b1;
        #4;
        check("mis_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        check("mis_flag", {63'd0, misalign_o}, 64'd1);
        check("mis_out_valid", {63'd0, out_valid}, 64'd1);
        check("mis_wben", {63'd0, wben_o}, 64'd0);
        check("mis_stall", {63'd0, stall_o}, 64'd0);
        check("mis_lsres", lsres_o, 64'd0);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  f3;
        logic        ld;
        logic [63:0] sd;
        logic [63:0] rd;
        int          rdy;
        int          rspd;
        logic [63:0] e_ls;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{64'h1003, 3'b000, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 0, 2, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
        vecs[1] = '{64'h2006, 3'b001, 1'b0, 64'hABCD, 64'h0, 3, 1, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000};
        vecs[2] = '{64'h3004, 3'b110, 1'b1, 64'h0, 64'hF000_0000_0000_0000, 0, 1, 64'h0000_0000_F000_0000, 8'h00, 64'h0};
        vecs[3] = '{64'h3004, 3'b010, 1'b1, 64'h0, 64'hF000_0000_0000_0000, 1, 1, 64'hFFFF_FFFF_F000_0000, 8'h00, 64'h0};
        vecs[4] = '{64'h4000, 3'b011, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 3, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
        vecs[5] = '{64'h5007, 3'b100, 1'b1, 64'h0, 64'h8100_0000_0000_0000, 2, 2, 64'h0000_0000_0000_0081, 8'h00, 64'h0};
        vecs[6] = '{64'h6005, 3'b000, 1'b0, 64'h5A, 64'h0, 0, 1, 64'h0, 8'h20, 64'h0000_5A00_0000_0000};
        vecs[7] = '{64'h7000, 3'b011, 1'b0, 64'h1122_3344_5566_7788, 64'h0, 1, 2, 64'h0, 8'hFF, 64'h1122_3344_5566_7788};
        vecs[8] = '{64'h8002, 3'b001, 1'b1, 64'h0, 64'h0000_0000_8765_0000, 0, 1, 64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'h0};
        vecs[9] = '{64'h9000, 3'b111, 1'b1, 64'h0, 64'hDEAD_BEEF_CAFE_BABE, 0, 1, 64'hDEAD_BEEF_CAFE_BABE, 8'h00, 64'h0};

        pc_i = 64'h0; instr_i = 32'h13; alures_i = 64'h0; stdata_i = 64'h0;
        csrdata_i = 64'h0; funct3_i = 3'b000; dmem_rdata = 64'h0;
        clear_inputs();

        // Reset with a valid ALU op present: every output must stay low.
        rst = 1'b1; in_valid = 1'b1; alures_i = 64'h1234; wben_i = 1'b1;
        repeat (2) begin
            @(posedge clk); #5;
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_alures", alures_o, 64'd0);
            check("rst_wben", {63'd0, wben_o}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD pass-through is combinational.
        #4;
        check("add_out_valid", {63'd0, out_valid}, 64'd1);
        check("add_wben", {63'd0, wben_o}, 64'd1);
        check("add_alures", alures_o, 64'h1234);
        check("add_stall", {63'd0, stall_o}, 64'd0);
        check("add_lsres", lsres_o, 64'd0);
        @(posedge clk); #1;
        clear_inputs();

        // Reset held two cycles mid-RESP abandons the access.
        in_valid = 1'b1; is_load_i = 1'b1; alures_i = 64'h1000; funct3_i = 3'b011;
        dmem_req_ready = 1'b1;
        #4;
        check("pre_rst_req", {63'd0, dmem_req_valid}, 64'd1);
        @(posedge clk); #1;
        clear_inputs();
        #4;
        check("resp_stall", {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0; dmem_resp_valid = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            #4;
            check("post_rst_stall", {63'd0, stall_o}, 64'd0);
            check("post_rst_req", {63'd0, dmem_req_valid}, 64'd0);
            check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("post_rst_lsres", lsres_o, 64'd0);
            @(posedge clk); #1;
        end
        clear_inputs();

        for (int i = 0; i < 10; i++) begin
            run_mem(vecs[i].addr, vecs[i].f3, vecs[i].ld, vecs[i].sd, vecs[i].rd,
                    vecs[i].rdy, vecs[i].rspd, 1'b0, 1'b0, vecs[i].e_ls,
                    vecs[i].e_mask, vecs[i].e_wdata);
        end

        run_misaligned(64'h4004, 3'b011, 1'b1);
        run_misaligned(64'h2006, 3'b010, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int          kind, off, rdy, rspd;
            logic [2:0]  f3;
            logic        ld;
            logic [63:0] addr, sd, rd;
            kind = $urandom_range(0, 3);
            off  = $urandom_range(0, 7);
            addr = {$urandom, $urandom};
            addr[2:0] = off[2:0];
            sd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            rdy  = $urandom_range(0, 3);
            rspd = $urandom_range(1, 3);
            if (kind == 0) begin
                logic iv, wb;
                iv = 1'($urandom_range(0, 1));
                wb = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                in_valid = iv; alures_i = addr; wben_i = wb;
                is_load_i = 1'b0; is_store_i = 1'b0;
                #4;
                check("alu_out_valid", {63'd0, out_valid}, {63'd0, iv});
                check("alu_wben", {63'd0, wben_o}, {63'd0, iv & wb});
                check("alu_stall", {63'd0, stall_o}, 64'd0);
                check("alu_alures", alures_o, addr);
                @(posedge clk); #1;
                clear_inputs();
            end else begin
                ld = (kind != 1);
                f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                if (off + m_size(f3) > 8) begin
                    run_misaligned(addr, f3, ld);
                end else begin
                    run_mem(addr, f3, ld, sd, rd, rdy, rspd, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)),
                            ld ? m_load(rd, off, f3) : 64'h0,
                            m_mask(off, m_size(f3)), sd << (8 * off));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
